// File: rtl/get_column_1_unit_pkg.sv
// rtl/get_column_1_unit_pkg.sv - shared widths, FSM encoding and Q1.15 constants
// Purpose : constants shared by the column-1 normaliser, its interface and dividers.
// Ports   : none (package).
package get_column_1_unit_pkg;

    localparam int DW    = 16;   // matrix element width
    localparam int AW    = 17;   // amplitude width (DW+1)
    localparam int FRAC  = 15;   // fraction bits of the Q1.15 result
    localparam int QBITS = 16;   // quotient bits produced, one per DIV cycle

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_DIV  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    localparam logic [DW-1:0] ONE = 16'h8000;   // 1.0 in Q1.15
    localparam logic [DW-1:0] SAT = 16'hFFFF;   // result when a > amp

endpackage

// File: rtl/get_column_1_unit_if.sv
// rtl/get_column_1_unit_if.sv - request/result bundle of the column-1 normaliser
// Purpose : groups the amplitude request and the normalised result.
// Ports   : I_amp_valid, I_column_1_amp, I_a11, I_a21 (request, master -> slave);
//           O_q11, O_q21, O_q_valid, O_div_zero, O_busy (result, slave -> master).
interface get_column_1_unit_if;
    import get_column_1_unit_pkg::*;

    logic          I_amp_valid;
    logic [AW-1:0] I_column_1_amp;
    logic [DW-1:0] I_a11;
    logic [DW-1:0] I_a21;
    logic [DW-1:0] O_q11;
    logic [DW-1:0] O_q21;
    logic          O_q_valid;
    logic          O_div_zero;
    logic          O_busy;

    modport slave (
        input  I_amp_valid, I_column_1_amp, I_a11, I_a21,
        output O_q11, O_q21, O_q_valid, O_div_zero, O_busy
    );

    modport master (
        output I_amp_valid, I_column_1_amp, I_a11, I_a21,
        input  O_q11, O_q21, O_q_valid, O_div_zero, O_busy
    );

endinterface

// File: rtl/get_column_1_unit_serial_divider.sv
// rtl/get_column_1_unit_serial_divider.sv - bit-serial restoring divider, one quotient bit per step
// Purpose : computes floor((i_dividend << SHIFT) / i_divisor) as a QBITS-bit quotient.
// Ports   : clk, rstn            - clock, synchronous active-low reset
//           i_start              - load a new dividend (divisor must be stable from the next cycle)
//           i_step               - perform one restoring iteration
//           i_dividend, i_divisor- operands
//           o_quot               - registered quotient
//           o_quot_next          - quotient including the current step's bit
module serial_divider
    import get_column_1_unit_pkg::*;
#(
    parameter int DW_P    = DW,
    parameter int AW_P    = AW,
    parameter int SHIFT   = FRAC,
    parameter int QBITS_P = QBITS
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_start,
    input  logic               i_step,
    input  logic [DW_P-1:0]    i_dividend,
    input  logic [AW_P-1:0]    i_divisor,
    output logic [QBITS_P-1:0] o_quot,
    output logic [QBITS_P-1:0] o_quot_next
);

    localparam int XW = DW_P + SHIFT;    // full dividend width
    localparam int HW = XW - QBITS_P;    // dividend bits preloaded into the remainder
    localparam int RW = AW_P + 1;        // remainder width

    logic [RW-1:0]      rem_q, rem_d;
    logic [QBITS_P-1:0] low_q, low_d;    // dividend bits still to be brought in, MSB first
    logic [QBITS_P-1:0] quot_q, quot_d;
    logic [XW-1:0]      ext;
    logic [RW:0]        rem_sh;
    logic [RW:0]        diff;
    logic               qbit;

    always_comb begin
        ext    = {i_dividend, {SHIFT{1'b0}}};
        rem_sh = {rem_q, low_q[QBITS_P-1]};
        diff   = rem_sh - {2'b00, i_divisor};
        // The preloaded upper bits are below the divisor whenever a < 2*amp, so only
        // the low QBITS quotient bits can be non-zero; a negative trial means restore.
        qbit        = ~diff[RW];
        o_quot_next = {quot_q[QBITS_P-2:0], qbit};

        rem_d  = rem_q;
        low_d  = low_q;
        quot_d = quot_q;
        if (i_start) begin
            rem_d  = {{(RW-HW){1'b0}}, ext[XW-1:QBITS_P]};
            low_d  = ext[QBITS_P-1:0];
            quot_d = '0;
        end else if (i_step) begin
            rem_d  = qbit ? diff[RW-1:0] : rem_sh[RW-1:0];
            low_d  = {low_q[QBITS_P-2:0], 1'b0};
            quot_d = o_quot_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rem_q  <= '0;
            low_q  <= '0;
            quot_q <= '0;
        end else begin
            rem_q  <= rem_d;
            low_q  <= low_d;
            quot_q <= quot_d;
        end
    end

    assign o_quot = quot_q;

endmodule

// File: rtl/get_column_1_unit.sv
// rtl/get_column_1_unit.sv - normalises matrix column 1 to unsigned Q1.15 (q = a/|col1|)
// Purpose : FSM, shared iteration counter, operand capture, zero/overflow handling and
//           output registers around two lockstep serial dividers.
// Ports   : I_sys_clk  - system clock
//           I_sys_rstn - synchronous active-low reset
//           bus        - request/result bundle (slave side)
module get_column_1_unit
    import get_column_1_unit_pkg::*;
(
    input  logic                 I_sys_clk,
    input  logic                 I_sys_rstn,
    get_column_1_unit_if.slave   bus
);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] amp_q, amp_d;
    logic          zero_q, zero_d;
    logic          ovf11_q, ovf11_d;
    logic          ovf21_q, ovf21_d;
    logic [DW-1:0] q11_q, q11_d;
    logic [DW-1:0] q21_q, q21_d;
    logic          dz_q, dz_d;
    logic          qv_q, qv_d;
    logic          start;
    logic          step;
    logic [DW-1:0] quot11, quot11_next;
    logic [DW-1:0] quot21, quot21_next;

    assign start = (state_q == S_IDLE) && bus.I_amp_valid;
    assign step  = (state_q == S_DIV);

    serial_divider u_div11 (
        .clk         (I_sys_clk),
        .rstn        (I_sys_rstn),
        .i_start     (start),
        .i_step      (step),
        .i_dividend  (bus.I_a11),
        .i_divisor   (amp_q),
        .o_quot      (quot11),
        .o_quot_next (quot11_next)
    );

    serial_divider u_div21 (
        .clk         (I_sys_clk),
        .rstn        (I_sys_rstn),
        .i_start     (start),
        .i_step      (step),
        .i_dividend  (bus.I_a21),
        .i_divisor   (amp_q),
        .o_quot      (quot21),
        .o_quot_next (quot21_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        amp_d   = amp_q;
        zero_d  = zero_q;
        ovf11_d = ovf11_q;
        ovf21_d = ovf21_q;
        q11_d   = q11_q;
        q21_d   = q21_q;
        dz_d    = dz_q;
        qv_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.I_amp_valid) begin
                    amp_d   = bus.I_column_1_amp;
                    zero_d  = (bus.I_column_1_amp == '0);
                    ovf11_d = ({1'b0, bus.I_a11} > bus.I_column_1_amp);
                    ovf21_d = ({1'b0, bus.I_a21} > bus.I_column_1_amp);
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                cnt_d = cnt_q + 4'd1;
                // The last iteration's bit is only in the divider's next-state value,
                // so results are taken from o_quot_next on the same edge.
                if (cnt_q == 4'(QBITS - 1)) begin
                    dz_d    = zero_q;
                    qv_d    = 1'b1;
                    state_d = S_DONE;
                    if (zero_q) begin
                        q11_d = '0;
                        q21_d = '0;
                    end else begin
                        q11_d = ovf11_q ? SAT : quot11_next;
                        q21_d = ovf21_q ? SAT : quot21_next;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_sys_clk) begin
        if (!I_sys_rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            amp_q   <= '0;
            zero_q  <= 1'b0;
            ovf11_q <= 1'b0;
            ovf21_q <= 1'b0;
            q11_q   <= '0;
            q21_q   <= '0;
            dz_q    <= 1'b0;
            qv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            amp_q   <= amp_d;
            zero_q  <= zero_d;
            ovf11_q <= ovf11_d;
            ovf21_q <= ovf21_d;
            q11_q   <= q11_d;
            q21_q   <= q21_d;
            dz_q    <= dz_d;
            qv_q    <= qv_d;
        end
    end

    // Registered quotients are observable only through the output registers.
    logic unused_quot;
    assign unused_quot = ^{quot11, quot21, ONE};

    assign bus.O_q11      = q11_q;
    assign bus.O_q21      = q21_q;
    assign bus.O_q_valid  = qv_q;
    assign bus.O_div_zero = dz_q;
    assign bus.O_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_get_column_1_unit.sv
// tb/tb_get_column_1_unit.sv - directed and randomised self-checking bench for get_column_1_unit
module tb_get_column_1_unit;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    get_column_1_unit_if u_if ();

    get_column_1_unit dut (
        .I_sys_clk  (clk),
        .I_sys_rstn (rstn),
        .bus        (u_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint isqrt(input longint v);
        longint r = 0;
        longint t;
        for (int b = 17; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= v) r = t;
        end
        return r;
    endfunction

    function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [16:0] amp);
        longint num;
        if (amp == 0) return 16'h0000;
        if ({1'b0, a} > amp) return 16'hFFFF;
        num = longint'(a) * 32768;
        return 16'(num / longint'(amp));
    endfunction

    // Issues one request at the next edge (edge T) and checks latency, busy and result.
    // inject: re-pulse I_amp_valid with a11=a21=amp=1 on edge T+5.
    task automatic run_op(input logic [15:0] a11, input logic [15:0] a21, input logic [16:0] amp,
                          input logic [15:0] e11, input logic [15:0] e21, input logic ez,
                          input bit inject);
        int n;
        bit got;
        u_if.I_a11          = a11;
        u_if.I_a21          = a21;
        u_if.I_column_1_amp = amp;
        u_if.I_amp_valid    = 1'b1;
        @(posedge clk); #1;
        u_if.I_amp_valid = 1'b0;
        check("busy_at_T", 32'(u_if.O_busy), 32'd1);
        n   = 0;
        got = 0;
        while (!got && n < 40) begin
            if (inject && n == 4) begin
                u_if.I_a11          = 16'd1;
                u_if.I_a21          = 16'd1;
                u_if.I_column_1_amp = 17'd1;
                u_if.I_amp_valid    = 1'b1;
            end
            @(posedge clk); #1;
            n++;
            u_if.I_amp_valid = 1'b0;
            if (u_if.O_q_valid) got = 1;
            else check("busy_in_div", 32'(u_if.O_busy), 32'd1);
        end
        check("latency", 32'(n), 32'd16);
        check("busy_at_valid", 32'(u_if.O_busy), 32'd1);
        check("q11", 32'(u_if.O_q11), 32'(e11));
        check("q21", 32'(u_if.O_q21), 32'(e21));
        check("div_zero", 32'(u_if.O_div_zero), 32'(ez));
        @(posedge clk); #1;
        check("valid_fall", 32'(u_if.O_q_valid), 32'd0);
        check("busy_fall", 32'(u_if.O_busy), 32'd0);
        check("q11_hold", 32'(u_if.O_q11), 32'(e11));
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (u_if.O_q_valid) pulses++;
        end
        check(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        logic [15:0] ra11, ra21;
        logic [16:0] ramp;

        rstn                = 1'b0;
        u_if.I_amp_valid    = 1'b0;
        u_if.I_a11          = '0;
        u_if.I_a21          = '0;
        u_if.I_column_1_amp = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q11", 32'(u_if.O_q11), 32'd0);
        check("rst_q21", 32'(u_if.O_q21), 32'd0);
        check("rst_valid", 32'(u_if.O_q_valid), 32'd0);
        check("rst_div_zero", 32'(u_if.O_div_zero), 32'd0);
        check("rst_busy", 32'(u_if.O_busy), 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // 3/5 and 4/5
        run_op(16'd3, 16'd4, 17'd5, 16'h4CCC, 16'h6666, 1'b0, 0);
        // full-scale: a == amp gives exactly 1.0
        run_op(16'hFFFF, 16'h0000, 17'h0FFFF, 16'h8000, 16'h0000, 1'b0, 0);
        // zero amplitude: forced zero result, same latency
        run_op(16'd0, 16'd0, 17'd0, 16'h0000, 16'h0000, 1'b1, 0);
        // a > amp saturates
        run_op(16'd5, 16'd0, 17'd3, 16'hFFFF, 16'h0000, 1'b0, 0);
        // equal small operands
        run_op(16'd1, 16'd1, 17'd1, 16'h8000, 16'h8000, 1'b0, 0);
        // request during busy is ignored
        run_op(16'd3, 16'd4, 17'd5, 16'h4CCC, 16'h6666, 1'b0, 1);
        watch_no_valid("no_extra_result", 20);

        // reset mid-operation, asserted so edge T+8 samples it
        u_if.I_a11          = 16'd3;
        u_if.I_a21          = 16'd4;
        u_if.I_column_1_amp = 17'd5;
        u_if.I_amp_valid    = 1'b1;
        @(posedge clk); #1;
        u_if.I_amp_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_q11", 32'(u_if.O_q11), 32'd0);
        check("mid_rst_q21", 32'(u_if.O_q21), 32'd0);
        check("mid_rst_valid", 32'(u_if.O_q_valid), 32'd0);
        check("mid_rst_div_zero", 32'(u_if.O_div_zero), 32'd0);
        check("mid_rst_busy", 32'(u_if.O_busy), 32'd0);
        rstn = 1'b1;
        watch_no_valid("no_valid_after_abort", 20);
        run_op(16'd3, 16'd4, 17'd5, 16'h4CCC, 16'h6666, 1'b0, 0);

        // back-to-back random requests at the earliest legal edge
        for (int i = 0; i < 1000; i++) begin
            ra11 = 16'($urandom_range(0, 65535));
            ra21 = 16'($urandom_range(0, 65535));
            if (i % 50 == 0) ra21 = 16'd0;
            ramp = 17'(isqrt(longint'(ra11) * ra11 + longint'(ra21) * ra21));
            run_op(ra11, ra21, ramp, ref_q(ra11, ramp), ref_q(ra21, ramp),
                   (ramp == 17'd0), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/get_column_1_unit.md
# get_column_1_unit

- Normalises column 1 of the 2×2 input matrix: produces q11 = a11/|col1| and q21 = a21/|col1| as unsigned Q1.15 fractions.
- Sits directly downstream of the column-1 amplitude stage and consumes its 17-bit amplitude and valid pulse; its outputs feed the Q-column / rotation stage of the inverse pipeline.
- Uses two identical bit-serial restoring dividers running in lockstep, with fixed latency.

## Interface

Parameters:
- DW, 16: element width; unsigned matrix entries.
- AW, 17: amplitude width, equal to DW+1.
- FRAC, 15: fraction bits of the result. The result is unsigned Q1.15, so 1.0 = 0x8000.

Ports (reset is synchronous, active-low, on the single clock I_sys_clk):
- I_sys_clk, input, 1: system clock; all logic is rising-edge.
- I_sys_rstn, input, 1: synchronous active-low reset.
- I_amp_valid, input, 1: single-cycle pulse from the amplitude stage.
- I_column_1_amp, input, AW: |col1| = sqrt(a11²+a21²); valid with I_amp_valid.
- I_a11, input, DW: matrix entry a11; the upstream stage holds it stable while I_amp_valid is high.
- I_a21, input, DW: matrix entry a21; same hold rule as I_a11.
- O_q11, output, DW: floor(a11·2^15 / amp), Q1.15.
- O_q21, output, DW: floor(a21·2^15 / amp), Q1.15.
- O_q_valid, output, 1: one-cycle pulse when O_q11/O_q21 are new.
- O_div_zero, output, 1: set with O_q_valid when the captured amp was 0.
- O_busy, output, 1: high whenever the state is not IDLE; new requests are ignored while high.

## Operation

- FSM states: IDLE, DIV, DONE.
- IDLE:
  - On I_amp_valid, capture amp, a11 and a21.
  - Clear the iteration counter and go to DIV.
  - Record zero_flag = (amp == 0).
- DIV: one restoring step per cycle in each divider, in parallel.
  - The dividend is a·2^FRAC (31 bits); the remainder is AW+1 bits wide.
  - Each step: shift the remainder left, bring in the next dividend bit, trial-subtract amp, and set the quotient bit to 1 if the result is non-negative (otherwise restore).
  - The counter runs 0..15 (16 iterations, one quotient bit each, MSB first).
  - The quotient is guaranteed ≤ 0x8000 because a ≤ amp; no saturation is needed. If a > amp (upstream inconsistency), the quotient saturates to 0xFFFF.
  - After the 16th iteration: load O_q11/O_q21 and O_div_zero, then go to DONE.
- zero_flag = 1: the dividers still run for the full 16 cycles, so latency stays constant. O_q11 and O_q21 are forced to 0 and O_div_zero = 1.
- DONE: O_q_valid = 1 for this cycle only; go to IDLE.
- I_amp_valid while O_busy = 1 (DIV or DONE): ignored, with no queueing. The upstream stage must not issue a new request before O_busy falls.
- Between results, O_q11, O_q21 and O_div_zero hold their last value.
- Reset (any state, including mid-DIV):
  - State → IDLE.
  - All outputs and internal registers → 0.
  - No O_q_valid pulse for the aborted operation.

## Timing

- Accept edge T: the edge where I_amp_valid = 1 and the state is IDLE.
- Iterations occur on edges T+1..T+16.
- At edge T+16, O_q11, O_q21 and O_div_zero update, and O_q_valid goes high (state DONE).
- At edge T+17, O_q_valid falls and the state returns to IDLE.
- Latency is 16 cycles from accept to valid. Next accept is possible no earlier than edge T+18, giving a throughput of 1 result per 18 cycles.
- O_busy is high from edge T through edge T+17.
- Reset values: O_q11 = 0, O_q21 = 0, O_q_valid = 0, O_div_zero = 0, O_busy = 0.

## Structure

- Shared package holds:
  - Width constants DW, AW, FRAC.
  - Iteration count QBITS = 16.
  - FSM state encoding (IDLE = 0, DIV = 1, DONE = 2).
  - Q1.15 constant ONE = 16'h8000.
- Sub-module serial_divider, instantiated twice:
  - Performs one restoring step per cycle under a start/step enable.
  - Takes a DW-bit dividend, a FRAC-bit left shift and an AW-bit divisor.
  - Exposes a DW-bit quotient.
- The top level holds the FSM, the shared counter, operand capture, zero handling and the output registers.

## Test plan

- a11=3, a21=4, amp=5 → after 16 cycles, O_q11=0x4CCC (19660), O_q21=0x6666 (26214), O_div_zero=0, and O_q_valid is high for exactly one cycle.
- a11=0xFFFF, a21=0, amp=0xFFFF → O_q11=0x8000, O_q21=0x0000.
- a11=0, a21=0, amp=0 → O_q11=O_q21=0, O_div_zero=1, and valid still arrives at T+16.
- Accept a11=3, a21=4, amp=5; pulse I_amp_valid again at T+5 with a11=a21=amp=1 → the second request is ignored, a single result equal to 0x4CCC/0x6666 is produced, and O_busy is high T..T+17.
- Deassert I_sys_rstn at T+8 of an operation → all outputs are 0 on the next edge, no O_q_valid appears, and a fresh request afterwards returns the correct result with 16-cycle latency.
- Random a11/a21 (amp computed by a reference model as floor(sqrt(a11²+a21²))), 1000 back-to-back requests issued at the earliest legal edge → every O_q equals floor(a·32768/amp) and every result has 16-cycle latency.
